pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Initiator side of the training/validation handshake that the neural-net architecture block answers.
- Fetches patterns (x, y) from a synchronous pattern ROM and drives TR/VL with stable x/y/lr until the architecture returns S_Train/S_Error.
- Counts validation errors per epoch, halves the learning rate on a schedule, and raises END when training finishes.
- Sits between the pattern memory and the architecture block.

Parameters:
- NX, 6: input vector length.
- BITS, 16: data word width.
- N_TRAIN, 64: training patterns per epoch (>=1).
- N_VAL, 16: validation patterns per epoch (>=1).
- EPOCHS, 8: maximum epoch count (>=1).
- AW, 8: pattern ROM address width; N_TRAIN+N_VAL <= 2^AW.
- LR_INIT, 16'h0100: initial learning rate.
- LR_DECAY, 4: lr halves every LR_DECAY completed epochs.
- EARLY_STOP, 1: stop when an epoch has zero validation errors.
- TIMEOUT, 4096: maximum cycles to wait for S_Train/S_Error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- pat_addr  out  AW  ROM address.
- pat_x  in  NX*BITS  ROM x data, valid one cycle after pat_addr.
- pat_y  in  BITS  ROM label, same timing as pat_x.
- TR  out  1  training request (level).
- VL  out  1  validation request (level).
- END  out  1  run complete (sticky until start or rst).
- x  out  NX*BITS  registered pattern vector.
- y  out  BITS  registered label.
- lr  out  BITS  current learning rate.
- S_Train  in  1  training pattern complete pulse.
- S_Error  in  1  validation pattern complete pulse.
- Error  in  BITS  per-pattern error; nonzero counts as a miss.
- epoch_done  out  1  one-cycle pulse at the end of each epoch.
- epoch_errs  out  AW  validation miss count of the last epoch.
- epoch_num  out  8  completed epoch count.
- fault  out  1  sticky handshake timeout flag.

Behaviour:
- Reset (asynchronous): state=IDLE; TR=VL=END=fault=epoch_done=0; x=y=0; lr=LR_INIT; pat_addr=0; epoch_errs=0; epoch_num=0; internal counters=0.
- Reset asserted mid-handshake drops TR/VL within the same cycle (asynchronous clear).
- State machine states: IDLE, FETCH_T, LOAD_T, TRAIN, FETCH_V, LOAD_V, VALID, EPOCH, DONE, FAULT.
- IDLE: on start, go to FETCH_T; idx=0, err_cnt=0, epoch_num=0, lr=LR_INIT, END=0, fault=0. start in any other state is ignored.
- FETCH_T: pat_addr=idx, then go to LOAD_T.
- LOAD_T: capture pat_x/pat_y into x/y, then go to TRAIN.
- TRAIN: TR=1, with x, y and lr held constant.
  - On S_Train: TR=0 on the next cycle.
  - If idx==N_TRAIN-1, go to FETCH_V with idx=0; otherwise idx+1 and go to FETCH_T.
  - TR is therefore low for at least 2 cycles between patterns.
- FETCH_V / LOAD_V: same as training, with pat_addr=N_TRAIN+idx.
- VALID: VL=1.
  - On S_Error: err_cnt += (Error!=0), saturating at 2^AW-1.
  - If idx==N_VAL-1, go to EPOCH; otherwise idx+1 and go to FETCH_V.
- EPOCH (exactly 1 cycle):
  - epoch_done=1, epoch_errs=err_cnt, epoch_num+1, err_cnt=0.
  - If the new epoch_num is a multiple of LR_DECAY: lr=lr>>1, floored at 1.
  - If epoch_num+1==EPOCHS, or (EARLY_STOP and err_cnt==0), go to DONE; otherwise go to FETCH_T.
- DONE: END=1, TR=VL=0; stay until start, which re-runs the sequence from IDLE entry actions.
- Timeout: a wait counter resets on entry to TRAIN/VALID.
  - If it reaches TIMEOUT-1 without a completion pulse: fault=1, go to FAULT (TR=VL=END=0).
  - Only rst or start leaves FAULT.
  - If the completion pulse and timeout coincide, the completion pulse wins.
- S_Train is ignored outside TRAIN and S_Error is ignored outside VALID. This includes pulses during the LOAD/FETCH cycles.
- TR and VL are never high together.

Decomposition:
- Shared package nn_pkg:
  - state enum seq_state_t.
  - defaults BITS, NX.
  - typedef word_t = logic [BITS-1:0].
- The timeout watchdog is a natural sub-module, hs_watchdog (clear, enable, expired).

Test Plan:
- N_TRAIN=2, N_VAL=1, EPOCHS=1; start; architecture model answers S_Train 3 cycles after TR rises -> pat_addr sequence 0,1,2; TR pulses twice then VL once; epoch_done pulse; END=1 thereafter.
- Validation with Error=1,0,1,1 (N_VAL=4, EARLY_STOP=0) -> epoch_errs=3; err_cnt cleared for the next epoch.
- LR_DECAY=2, EPOCHS=5, LR_INIT=16'h0100 -> lr=0x0100, 0x0100, 0x0080, 0x0080, 0x0040 at the start of epochs 1-5.
- EARLY_STOP=1, all Error=0 in epoch 1 -> DONE after epoch_num=1; END=1; no further TR.
- No S_Train, TIMEOUT=16 -> fault=1 and TR=0 at the 16th cycle of TRAIN; S_Train on that same cycle instead -> no fault, sequence advances.
- rst asserted while TR=1 -> TR=0 immediately, all outputs at reset values; a stray S_Train in IDLE/LOAD_T -> no state change.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and default widths for the neural-net training blocks.
package nn_pkg;

  localparam int unsigned BITS = 16;
  localparam int unsigned NX   = 6;

  typedef logic [BITS-1:0] word_t;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_T,
    LOAD_T,
    TRAIN,
    FETCH_V,
    LOAD_V,
    VALID,
    EPOCH,
    DONE,
    FAULT
  } seq_state_t;

endpackage

// File: rtl/hs_watchdog.sv
// Handshake watchdog: counts cycles while enabled and flags the last allowed cycle.
module hs_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // Next count: clear wins, otherwise count up and hold at the last value.
  always_comb begin
    cnt_nx = cnt;
    if (clear) begin
      cnt_nx = '0;
    end else if (enable && (cnt != LAST)) begin
      cnt_nx = cnt + CW'(1);
    end
  end

  // Counter register; expired is high during the cycle the count sits at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      expired <= (cnt_nx == LAST);
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Training/validation initiator: fetches ROM patterns, runs TR/VL handshakes,
// tracks per-epoch validation misses and the learning-rate schedule.
module pattern_sequencer #(
  parameter int unsigned NX         = nn_pkg::NX,
  parameter int unsigned BITS       = nn_pkg::BITS,
  parameter int unsigned N_TRAIN    = 64,
  parameter int unsigned N_VAL      = 16,
  parameter int unsigned EPOCHS     = 8,
  parameter int unsigned AW         = 8,
  parameter int unsigned LR_INIT    = 32'h0100,
  parameter int unsigned LR_DECAY   = 4,
  parameter int unsigned EARLY_STOP = 1,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [AW-1:0]      pat_addr,
  input  logic [NX*BITS-1:0] pat_x,
  input  logic [BITS-1:0]    pat_y,
  output logic               TR,
  output logic               VL,
  output logic               END,
  output logic [NX*BITS-1:0] x,
  output logic [BITS-1:0]    y,
  output logic [BITS-1:0]    lr,
  input  logic               S_Train,
  input  logic               S_Error,
  input  logic [BITS-1:0]    Error,
  output logic               epoch_done,
  output logic [AW-1:0]      epoch_errs,
  output logic [7:0]         epoch_num,
  output logic               fault
);

  import nn_pkg::*;

  localparam logic [BITS-1:0] LR_RST = BITS'(LR_INIT);

  seq_state_t state_q, state_d;

  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      err_q, err_d;
  logic [7:0]         decay_q, decay_d;
  logic [AW-1:0]      addr_d;
  logic [NX*BITS-1:0] x_d;
  logic [BITS-1:0]    y_d;
  logic [BITS-1:0]    lr_d;
  logic [BITS-1:0]    lr_half;
  logic [AW-1:0]      epoch_errs_d;
  logic [7:0]         epoch_num_d;
  logic               epoch_done_d;
  logic               fault_d;
  logic               tr_d, vl_d, end_d;
  logic               waiting;
  logic               expired;

  assign waiting = (state_q == TRAIN) || (state_q == VALID);

  hs_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );

  // Next-state and next-register logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    decay_d      = decay_q;
    addr_d       = pat_addr;
    x_d          = x;
    y_d          = y;
    lr_d         = lr;
    epoch_errs_d = epoch_errs;
    epoch_num_d  = epoch_num;
    epoch_done_d = 1'b0;
    fault_d      = fault;
    lr_half      = {1'b0, lr[BITS-1:1]};
    if (lr_half == '0) begin
      lr_half = BITS'(1);
    end

    case (state_q)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_d     = FETCH_T;
          idx_d       = '0;
          err_d       = '0;
          decay_d     = '0;
          epoch_num_d = '0;
          lr_d        = LR_RST;
          fault_d     = 1'b0;
        end
      end
      FETCH_T: state_d = LOAD_T;
      LOAD_T: begin
        x_d     = pat_x;
        y_d     = pat_y;
        state_d = TRAIN;
      end
      TRAIN: begin
        if (S_Train) begin
          if (idx_q == AW'(N_TRAIN - 1)) begin
            idx_d   = '0;
            state_d = FETCH_V;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH_T;
          end
        end else if (expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      FETCH_V: state_d = LOAD_V;
      LOAD_V: begin
        x_d     = pat_x;
        y_d     = pat_y;
        state_d = VALID;
      end
      VALID: begin
        if (S_Error) begin
          if ((Error != '0) && (err_q != '1)) begin
            err_d = err_q + AW'(1);
          end
          if (idx_q == AW'(N_VAL - 1)) begin
            idx_d   = '0;
            state_d = EPOCH;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH_V;
          end
        end else if (expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      EPOCH: begin
        epoch_done_d = 1'b1;
        epoch_errs_d = err_q;
        err_d        = '0;
        epoch_num_d  = epoch_num + 8'd1;
        if (LR_DECAY != 0) begin
          if (decay_q == 8'(LR_DECAY - 1)) begin
            decay_d = '0;
            lr_d    = lr_half;
          end else begin
            decay_d = decay_q + 8'd1;
          end
        end
        if ((epoch_num_d == 8'(EPOCHS)) || ((EARLY_STOP != 0) && (err_q == '0))) begin
          state_d = DONE;
        end else begin
          idx_d   = '0;
          state_d = FETCH_T;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == FETCH_T) begin
      addr_d = idx_d;
    end else if (state_d == FETCH_V) begin
      addr_d = AW'(N_TRAIN) + idx_d;
    end

    tr_d  = (state_d == TRAIN);
    vl_d  = (state_d == VALID);
    end_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      err_q      <= '0;
      decay_q    <= '0;
      pat_addr   <= '0;
      x          <= '0;
      y          <= '0;
      lr         <= LR_RST;
      epoch_errs <= '0;
      epoch_num  <= '0;
      epoch_done <= 1'b0;
      fault      <= 1'b0;
      TR         <= 1'b0;
      VL         <= 1'b0;
      END        <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      decay_q    <= decay_d;
      pat_addr   <= addr_d;
      x          <= x_d;
      y          <= y_d;
      lr         <= lr_d;
      epoch_errs <= epoch_errs_d;
      epoch_num  <= epoch_num_d;
      epoch_done <= epoch_done_d;
      fault      <= fault_d;
      TR         <= tr_d;
      VL         <= vl_d;
      END        <= end_d;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench: dut_a runs a 5-epoch schedule with timeouts, dut_b checks early stop.
module tb_pattern_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic s_train = 1'b0;
  logic s_error = 1'b0;
  logic [15:0] err_in = '0;

  logic [3:0]  addr_a, addr_b;
  logic [31:0] pat_x_a, pat_x_b, x_a, x_b;
  logic [15:0] pat_y_a, pat_y_b, y_a, y_b, lr_a, lr_b;
  logic        tr_a, vl_a, end_a, done_a, fault_a;
  logic        tr_b, vl_b, end_b, done_b, fault_b;
  logic [3:0]  errs_a, errs_b;
  logic [7:0]  num_a, num_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NX(2), .BITS(16), .N_TRAIN(2), .N_VAL(4), .EPOCHS(5), .AW(4),
    .LR_INIT(32'h0100), .LR_DECAY(2), .EARLY_STOP(0), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pat_addr(addr_a), .pat_x(pat_x_a),
    .pat_y(pat_y_a), .TR(tr_a), .VL(vl_a), .END(end_a), .x(x_a), .y(y_a), .lr(lr_a),
    .S_Train(s_train), .S_Error(s_error), .Error(err_in), .epoch_done(done_a),
    .epoch_errs(errs_a), .epoch_num(num_a), .fault(fault_a)
  );

  pattern_sequencer #(
    .NX(2), .BITS(16), .N_TRAIN(2), .N_VAL(1), .EPOCHS(3), .AW(4),
    .LR_INIT(32'h0100), .LR_DECAY(2), .EARLY_STOP(1), .TIMEOUT(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pat_addr(addr_b), .pat_x(pat_x_b),
    .pat_y(pat_y_b), .TR(tr_b), .VL(vl_b), .END(end_b), .x(x_b), .y(y_b), .lr(lr_b),
    .S_Train(s_train), .S_Error(s_error), .Error(err_in), .epoch_done(done_b),
    .epoch_errs(errs_b), .epoch_num(num_b), .fault(fault_b)
  );

  function automatic logic [31:0] rom_x(input logic [3:0] a);
    return {12'hA00, a, 12'h500, a};
  endfunction

  function automatic logic [15:0] rom_y(input logic [3:0] a);
    return {12'hC00, a};
  endfunction

  // Synchronous pattern ROMs, one cycle of read latency.
  always @(posedge clk) begin
    pat_x_a <= rom_x(addr_a);
    pat_y_a <= rom_y(addr_a);
    pat_x_b <= rom_x(addr_b);
    pat_y_b <= rom_y(addr_b);
  end

  function automatic logic cur_tr(input int sel);
    return (sel != 0) ? tr_b : tr_a;
  endfunction
  function automatic logic cur_vl(input int sel);
    return (sel != 0) ? vl_b : vl_a;
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_req(input int sel, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (cur_tr(sel) || cur_vl(sel)) got = 1'b1;
    end
    if (!got) chk("req_wait", 64'd0, 64'd1);
  endtask

  // One request/response exchange, answered 3 cycles after the request rises.
  task automatic handshake(input int sel, input bit is_val, input int addr,
                           input logic [15:0] err, input logic [15:0] exp_lr);
    bit got;
    wait_req(sel, got);
    if (!got) return;
    chk("req_kind", {62'd0, cur_tr(sel), cur_vl(sel)}, is_val ? 64'd1 : 64'd2);
    chk("pat_addr", (sel != 0) ? 64'(addr_b) : 64'(addr_a), 64'(addr));
    chk("x", (sel != 0) ? 64'(x_b) : 64'(x_a), 64'(rom_x(4'(addr))));
    chk("y", (sel != 0) ? 64'(y_b) : 64'(y_a), 64'(rom_y(4'(addr))));
    chk("lr", (sel != 0) ? 64'(lr_b) : 64'(lr_a), 64'(exp_lr));
    repeat (2) @(negedge clk);
    chk("req_held", 64'(cur_tr(sel) | cur_vl(sel)), 64'd1);
    if (is_val) begin
      s_error = 1'b1;
      err_in  = err;
    end else begin
      s_train = 1'b1;
    end
    @(negedge clk);
    s_train = 1'b0;
    s_error = 1'b0;
    err_in  = '0;
    chk("req_drop", 64'(cur_tr(sel) | cur_vl(sel)), 64'd0);
  endtask

  task automatic wait_epoch(input int sel, input int exp_errs, input int exp_num);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (cur_done(sel)) got = 1'b1;
    end
    chk("epoch_done_seen", 64'(got), 64'd1);
    chk("epoch_errs", (sel != 0) ? 64'(errs_b) : 64'(errs_a), 64'(exp_errs));
    chk("epoch_num", (sel != 0) ? 64'(num_b) : 64'(num_a), 64'(exp_num));
    @(negedge clk);
    chk("epoch_done_pulse", 64'(cur_done(sel)), 64'd0);
  endtask

  task automatic check_reset_a();
    chk("rst_tr", 64'(tr_a), 64'd0);
    chk("rst_vl", 64'(vl_a), 64'd0);
    chk("rst_end", 64'(end_a), 64'd0);
    chk("rst_fault", 64'(fault_a), 64'd0);
    chk("rst_epoch_done", 64'(done_a), 64'd0);
    chk("rst_x", 64'(x_a), 64'd0);
    chk("rst_y", 64'(y_a), 64'd0);
    chk("rst_lr", 64'(lr_a), 64'h0100);
    chk("rst_addr", 64'(addr_a), 64'd0);
    chk("rst_errs", 64'(errs_a), 64'd0);
    chk("rst_num", 64'(num_a), 64'd0);
    chk("rst_tr_b", 64'(tr_b), 64'd0);
  endtask

  typedef struct {
    bit          is_val;
    int          addr;
    logic [15:0] err;
    logic [15:0] lr;
    bit          ep_end;
    int          ep_errs;
    int          ep_num;
  } vec_t;

  vec_t        tbl [30];
  logic [15:0] lr_tab   [5]    = '{16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0040};
  logic [15:0] err_tab  [5][4] = '{'{16'd1, 16'd0, 16'd1, 16'd1},
                                   '{16'd0, 16'd0, 16'd0, 16'd0},
                                   '{16'd5, 16'd0, 16'd0, 16'd0},
                                   '{16'd0, 16'd0, 16'd0, 16'd2},
                                   '{16'd1, 16'd1, 16'd1, 16'd1}};
  int          errs_tab [5]    = '{3, 0, 1, 1, 4};

  initial begin
    bit got;
    int n;
    int tr_cnt;

    // Per epoch: train addresses 0,1 then validation addresses 2..5.
    n = 0;
    for (int e = 0; e < 5; e++) begin
      for (int t = 0; t < 2; t++) begin
        tbl[n] = '{1'b0, t, 16'd0, lr_tab[e], 1'b0, 0, 0};
        n++;
      end
      for (int v = 0; v < 4; v++) begin
        tbl[n] = '{1'b1, 2 + v, err_tab[e][v], lr_tab[e], (v == 3), errs_tab[e], e + 1};
        n++;
      end
    end

    repeat (3) @(negedge clk);
    check_reset_a();
    rst = 1'b0;

    // Full 5-epoch schedule on dut_a.
    pulse_start(0);
    for (int i = 0; i < 30; i++) begin
      handshake(0, tbl[i].is_val, tbl[i].addr, tbl[i].err, tbl[i].lr);
      if (tbl[i].ep_end) wait_epoch(0, tbl[i].ep_errs, tbl[i].ep_num);
    end
    chk("a_end", 64'(end_a), 64'd1);

    // Early stop on dut_b; dut_a sits in DONE and must ignore these pulses.
    pulse_start(1);
    handshake(1, 1'b0, 0, 16'd0, 16'h0100);
    handshake(1, 1'b0, 1, 16'd0, 16'h0100);
    handshake(1, 1'b1, 2, 16'd0, 16'h0100);
    wait_epoch(1, 0, 1);
    chk("b_end", 64'(end_b), 64'd1);
    tr_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tr_b || vl_b) tr_cnt++;
    end
    chk("b_no_more_req", 64'(tr_cnt), 64'd0);
    chk("b_end_sticky", 64'(end_b), 64'd1);
    chk("a_end_sticky", 64'(end_a), 64'd1);
    chk("a_num_hold", 64'(num_a), 64'd5);

    // Timeout with no S_Train: fault after the 16th TRAIN cycle.
    pulse_start(0);
    chk("end_cleared", 64'(end_a), 64'd0);
    wait_req(0, got);
    if (got) begin
      repeat (15) @(negedge clk);
      chk("to_tr_cycle16", 64'(tr_a), 64'd1);
      chk("to_fault_cycle16", 64'(fault_a), 64'd0);
      @(negedge clk);
      chk("to_fault", 64'(fault_a), 64'd1);
      chk("to_tr_drop", 64'(tr_a), 64'd0);
      chk("to_end", 64'(end_a), 64'd0);
      repeat (5) @(negedge clk);
      chk("fault_sticky", 64'(fault_a), 64'd1);
    end

    // Completion pulse on the expiring cycle wins over the timeout.
    pulse_start(0);
    chk("fault_cleared", 64'(fault_a), 64'd0);
    wait_req(0, got);
    if (got) begin
      repeat (15) @(negedge clk);
      s_train = 1'b1;
      @(negedge clk);
      s_train = 1'b0;
      chk("race_fault", 64'(fault_a), 64'd0);
      chk("race_tr_drop", 64'(tr_a), 64'd0);
      wait_req(0, got);
      chk("race_advance_addr", 64'(addr_a), 64'd1);
      chk("race_advance_x", 64'(x_a), 64'(rom_x(4'd1)));
    end

    // Asynchronous reset while TR is high.
    #2 rst = 1'b1;
    #1 check_reset_a();
    @(negedge clk);
    rst = 1'b0;

    // Stray S_Train in IDLE.
    @(negedge clk);
    s_train = 1'b1;
    @(negedge clk);
    s_train = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stray_tr", 64'(tr_a), 64'd0);
    chk("idle_stray_addr", 64'(addr_a), 64'd0);

    // Stray S_Train during LOAD_T must not complete the upcoming handshake.
    pulse_start(0);
    @(negedge clk);
    s_train = 1'b1;
    @(negedge clk);
    s_train = 1'b0;
    chk("load_stray_tr_rise", 64'(tr_a), 64'd1);
    @(negedge clk);
    chk("load_stray_tr_held", 64'(tr_a), 64'd1);
    chk("load_stray_addr", 64'(addr_a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
